// File: rtl/hdmi_init_seq.sv
// hdmi_init_seq: power-up / recovery sequencer for the HDMI TX/RX chips and
// the I2C configuration engine. Holds chips in reset, lets them settle, runs
// configuration under a timeout, and retries a bounded number of times.
module hdmi_init_seq #(
  parameter int unsigned RST_HOLD_CYCLES = 270000,
  parameter int unsigned SETTLE_CYCLES   = 540000,
  parameter int unsigned TIMEOUT_CYCLES  = 2700000,
  parameter int unsigned MAX_RETRY       = 3,
  parameter int unsigned CNT_W           = 22
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       restart,
  input  logic       cfg_done,
  input  logic       cfg_error,
  output logic       cfg_rst,
  output logic       hdmi_nreset,
  output logic       hdmi_in_nreset,
  output logic       ready,
  output logic       fail,
  output logic [2:0] attempt,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_HOLD   = 3'd0,
    S_SETTLE = 3'd1,
    S_CONFIG = 3'd2,
    S_DONE   = 3'd3,
    S_FAIL   = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(RST_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  // attempt is a 3-bit field, so the retry limit saturates at 7
  localparam int unsigned      RETRY_CAP    = (MAX_RETRY > 7) ? 7 : MAX_RETRY;
  localparam logic [2:0]       RETRY_LIM    = 3'(RETRY_CAP);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       attempt_q, attempt_d;
  logic             cfg_rst_q, cfg_rst_d;
  logic             chip_nrst_q, chip_nrst_d;
  logic             ready_q, ready_d;
  logic             fail_q, fail_d;
  logic             attempt_failed;

  // Next-state, counter and attempt logic; outputs decoded from the next state
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    attempt_d      = attempt_q;
    attempt_failed = 1'b0;

    unique case (state_q)
      S_HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          state_d = S_SETTLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          state_d = S_CONFIG;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_CONFIG: begin
        if (cfg_error || (!cfg_done && (cnt_q == TIMEOUT_LAST))) begin
          attempt_failed = 1'b1;
        end else if (cfg_done) begin
          state_d = S_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE, S_FAIL: begin
        state_d = state_q;
      end
      default: begin
        state_d = S_HOLD;
        cnt_d   = '0;
      end
    endcase

    if (attempt_failed) begin
      cnt_d = '0;
      if (attempt_q < RETRY_LIM) begin
        attempt_d = attempt_q + 3'd1;
        state_d   = S_HOLD;
      end else begin
        state_d = S_FAIL;
      end
    end

    if (restart) begin
      state_d   = S_HOLD;
      cnt_d     = '0;
      attempt_d = '0;
    end

    chip_nrst_d = (state_d != S_HOLD);
    cfg_rst_d   = (state_d == S_HOLD) || (state_d == S_SETTLE) || (state_d == S_FAIL);
    ready_d     = (state_d == S_DONE);
    fail_d      = (state_d == S_FAIL);
  end

  // State, counter and registered output flops with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_HOLD;
      cnt_q       <= '0;
      attempt_q   <= '0;
      chip_nrst_q <= 1'b0;
      cfg_rst_q   <= 1'b1;
      ready_q     <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      attempt_q   <= attempt_d;
      chip_nrst_q <= chip_nrst_d;
      cfg_rst_q   <= cfg_rst_d;
      ready_q     <= ready_d;
      fail_q      <= fail_d;
    end
  end

  assign cfg_rst        = cfg_rst_q;
  assign hdmi_nreset    = chip_nrst_q;
  assign hdmi_in_nreset = chip_nrst_q;
  assign ready          = ready_q;
  assign fail           = fail_q;
  assign attempt        = attempt_q;
  assign state          = state_q;

endmodule

// File: tb/tb_hdmi_init_seq.sv
// tb_hdmi_init_seq: directed scenarios followed by random stimulus, every
// cycle compared against a phase/duration reference model.
module tb_hdmi_init_seq;

  localparam int unsigned RH = 4;
  localparam int unsigned ST = 3;
  localparam int unsigned TO = 10;
  localparam int unsigned MR = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       restart = 1'b0;
  logic       cfg_done = 1'b0;
  logic       cfg_error = 1'b0;
  logic       cfg_rst, hdmi_nreset, hdmi_in_nreset, ready, fail;
  logic [2:0] attempt, state;

  int total = 0;
  int bad   = 0;

  // reference model: phase number (published debug code), cycles spent in phase, attempt
  int m_phase   = 0;
  int m_elapsed = 0;
  int m_att     = 0;

  always #5 clk = ~clk;

  hdmi_init_seq #(
    .RST_HOLD_CYCLES(RH),
    .SETTLE_CYCLES  (ST),
    .TIMEOUT_CYCLES (TO),
    .MAX_RETRY      (MR),
    .CNT_W          (4)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .restart       (restart),
    .cfg_done      (cfg_done),
    .cfg_error     (cfg_error),
    .cfg_rst       (cfg_rst),
    .hdmi_nreset   (hdmi_nreset),
    .hdmi_in_nreset(hdmi_in_nreset),
    .ready         (ready),
    .fail          (fail),
    .attempt       (attempt),
    .state         (state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // advance the model by one clock edge using the inputs presented at that edge
  task automatic model_edge();
    int unsigned dur;
    if (!rst_n || restart) begin
      m_phase = 0; m_elapsed = 0; m_att = 0;
    end else if (m_phase == 0 || m_phase == 1) begin
      dur = (m_phase == 0) ? RH : ST;
      m_elapsed++;
      if (m_elapsed == int'(dur)) begin
        m_phase++;
        m_elapsed = 0;
      end
    end else if (m_phase == 2) begin
      m_elapsed++;
      if (cfg_error || (!cfg_done && m_elapsed == int'(TO))) begin
        m_elapsed = 0;
        if (m_att < int'(MR)) begin
          m_att++;
          m_phase = 0;
        end else begin
          m_phase = 4;
        end
      end else if (cfg_done) begin
        m_phase = 3;
        m_elapsed = 0;
      end
    end
  endtask

  task automatic check_all();
    check("state",          {29'b0, state},   m_phase);
    check("attempt",        {29'b0, attempt}, m_att);
    check("hdmi_nreset",    {31'b0, hdmi_nreset},    (m_phase != 0) ? 1 : 0);
    check("hdmi_in_nreset", {31'b0, hdmi_in_nreset}, (m_phase != 0) ? 1 : 0);
    check("cfg_rst",        {31'b0, cfg_rst},
          (m_phase == 0 || m_phase == 1 || m_phase == 4) ? 1 : 0);
    check("ready",          {31'b0, ready}, (m_phase == 3) ? 1 : 0);
    check("fail",           {31'b0, fail},  (m_phase == 4) ? 1 : 0);
  endtask

  task automatic step(input logic r, input logic rs, input logic d, input logic e);
    rst_n = r; restart = rs; cfg_done = d; cfg_error = e;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic wait_config();
    int n = 0;
    while (m_phase != 2 && n < 50) begin
      step(1'b1, 1'b0, 1'b0, 1'b0);
      n++;
    end
    check("reach_config", (m_phase == 2) ? 1 : 0, 1);
  endtask

  // count consecutive post-edge samples with chip resets low, starting now
  task automatic count_low(output int low);
    int n = 0;
    low = (hdmi_nreset === 1'b0) ? 1 : 0;
    while (hdmi_nreset === 1'b0 && n < 20) begin
      step(1'b1, 1'b0, 1'b0, 1'b0);
      if (hdmi_nreset === 1'b0) low++;
      n++;
    end
  endtask

  initial begin
    int rise_edge;
    int fall_edge;
    int low;
    int cfg_cycles;

    // reset values
    repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0);
    check("rst_state",   {29'b0, state}, 0);
    check("rst_cfg_rst", {31'b0, cfg_rst}, 1);

    // 1: normal bring-up
    rise_edge = -1; fall_edge = -1;
    for (int k = 0; k < 12; k++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0);
      if (rise_edge < 0 && hdmi_nreset === 1'b1) rise_edge = k;
      if (fall_edge < 0 && cfg_rst === 1'b0) fall_edge = k;
    end
    check("s1_chip_release_edge", rise_edge, 3);
    check("s1_cfg_release_edge",  fall_edge, 6);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    check("s1_ready",   {31'b0, ready}, 1);
    check("s1_attempt", {29'b0, attempt}, 0);
    repeat (3) step(1'b1, 1'b0, 1'b0, 1'b1);   // ignored in DONE
    check("s1_done_sticky", {31'b0, ready}, 1);

    // 5a: restart from DONE; 2: retry on error
    step(1'b1, 1'b1, 1'b0, 1'b0);
    check("s5_done_restart_ready", {31'b0, ready}, 0);
    check("s5_done_restart_nrst",  {31'b0, hdmi_nreset}, 0);
    for (int a = 0; a < 2; a++) begin
      wait_config();
      step(1'b1, 1'b0, 1'b0, 1'b1);
      check("s2_attempt_step", {29'b0, attempt}, a + 1);
      count_low(low);
      check("s2_retry_low_cycles", low, 4);
    end
    wait_config();
    step(1'b1, 1'b0, 1'b1, 1'b0);
    check("s2_ready",   {31'b0, ready}, 1);
    check("s2_fail",    {31'b0, fail}, 0);
    check("s2_attempt", {29'b0, attempt}, 2);

    // 3: timeout exhaustion
    step(1'b1, 1'b1, 1'b0, 1'b0);
    cfg_cycles = 0;
    repeat (60) begin
      step(1'b1, 1'b0, 1'b0, 1'b0);
      if (cfg_rst === 1'b0) cfg_cycles++;
    end
    check("s3_config_cycles", cfg_cycles, 30);
    check("s3_state",   {29'b0, state}, 4);
    check("s3_fail",    {31'b0, fail}, 1);
    check("s3_attempt", {29'b0, attempt}, 2);
    check("s3_nrst",    {31'b0, hdmi_nreset}, 1);

    // 5b: restart from FAIL
    step(1'b1, 1'b1, 1'b0, 1'b0);
    check("s5_fail_restart_fail",  {31'b0, fail}, 0);
    check("s5_fail_restart_state", {29'b0, state}, 0);

    // 4: simultaneous done and error
    wait_config();
    step(1'b1, 1'b0, 1'b1, 1'b1);
    check("s4_attempt", {29'b0, attempt}, 1);
    check("s4_state",   {29'b0, state}, 0);
    check("s4_ready",   {31'b0, ready}, 0);

    // 5c: restart mid-HOLD restarts the full hold
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    check("s5_hold_restart_attempt", {29'b0, attempt}, 0);
    count_low(low);
    check("s5_hold_restart_low_cycles", low, 4);

    // 6: reset mid-CONFIG with restart, done during reset ignored
    wait_config();
    step(1'b0, 1'b1, 1'b1, 1'b0);
    check("s6_state",   {29'b0, state}, 0);
    check("s6_cfg_rst", {31'b0, cfg_rst}, 1);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check("s6_after_state", {29'b0, state}, 0);
    check("s6_after_ready", {31'b0, ready}, 0);

    // random stimulus against the model
    repeat (3000) begin
      step(($urandom_range(63) != 0), ($urandom_range(39) == 0),
           ($urandom_range(11) == 0), ($urandom_range(15) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hdmi_init_seq.md
# hdmi_init_seq

Power-up and recovery sequencer for the HDMI loop board path, running on the 27 MHz PLL clock. It holds the HDMI transmitter and receiver in reset, then releases them and waits for the chips to settle. It then releases the I2C register-configuration engine and supervises it until it reports done. On error or timeout it re-runs the whole sequence, up to a bounded number of retries. It replaces the direct tie of the chip resets and the configuration reset to PLL lock.

## Interface

Parameters:

- RST_HOLD_CYCLES, 270000 — cycles the chip resets are held low per attempt (10 ms at 27 MHz); must be ≥1.
- SETTLE_CYCLES, 540000 — cycles between chip reset release and configuration start (20 ms); must be ≥1.
- TIMEOUT_CYCLES, 2700000 — maximum cycles in CONFIG before the attempt is declared failed (100 ms); must be ≥1.
- MAX_RETRY, 3 — retries after the first attempt; total attempts = MAX_RETRY+1.
- CNT_W, 22 — width of the shared cycle counter; must hold max(RST_HOLD_CYCLES, SETTLE_CYCLES, TIMEOUT_CYCLES)−1.

Ports:

- clk  in  1  — 27 MHz configuration clock; the only clock.
- rst_n  in  1  — synchronous, active-low reset, sampled on rising clk. Driven from PLL locked.
- restart  in  1  — single-cycle request to rerun the sequence from scratch, e.g. after a hot-plug.
- cfg_done  in  1  — done level from the I2C configuration engine.
- cfg_error  in  1  — error level from the I2C configuration engine.
- cfg_rst  out  1  — active-high reset to the I2C configuration engine.
- hdmi_nreset  out  1  — active-low reset to the HDMI transmitter.
- hdmi_in_nreset  out  1  — active-low reset to the HDMI receiver.
- ready  out  1  — configuration completed successfully.
- fail  out  1  — all attempts exhausted.
- attempt  out  3  — index of the current/last attempt, starting at 0; saturates at 7.
- state  out  3  — FSM state encoding, for debug.

## Operation

FSM state encodings:

- HOLD = 0: hdmi_nreset=0, hdmi_in_nreset=0, cfg_rst=1.
- SETTLE = 1: hdmi_nreset=1, hdmi_in_nreset=1, cfg_rst=1.
- CONFIG = 2: chip resets high, cfg_rst=0.
- DONE = 3: chip resets high, cfg_rst=0, ready=1.
- FAIL = 4: chip resets high, cfg_rst=1, fail=1.

Counter and transitions:

- One counter `cnt` is cleared on every state entry and increments each cycle while in HOLD, SETTLE or CONFIG.
- HOLD → SETTLE when cnt==RST_HOLD_CYCLES−1.
- SETTLE → CONFIG when cnt==SETTLE_CYCLES−1.
- CONFIG is left on the first of three events:
  - cfg_error=1 → attempt fails. If cfg_error and cfg_done are both high in the same cycle, error wins.
  - cfg_done=1 (and cfg_error=0) → DONE.
  - cnt==TIMEOUT_CYCLES−1 with neither input high → attempt fails.
- On a failed attempt:
  - if attempt<MAX_RETRY, attempt increments and the FSM goes to HOLD, so the chips are reset again;
  - otherwise the FSM goes to FAIL.
- DONE and FAIL are terminal. cfg_done and cfg_error are ignored outside CONFIG.
- restart=1 in any state (including HOLD mid-count) forces HOLD with cnt=0 and attempt=0 on the next edge. restart takes priority over every other transition in that cycle.
- rst_n=0 overrides restart.

## Timing

- All outputs are registered and are direct decodes of the state register, so output changes coincide with the state change.
- Reset values (rst_n=0 at an edge) and the state on the first edge after rst_n rises:
  - Reset values: state=HOLD, cnt=0, attempt=0, hdmi_nreset=0, hdmi_in_nreset=0, cfg_rst=1, ready=0, fail=0.
  - After rst_n rises, the FSM counts from HOLD with cnt=0.
- Let edge 0 be the first edge with rst_n=1.
  - hdmi_nreset and hdmi_in_nreset rise after edge RST_HOLD_CYCLES−1.
  - cfg_rst falls after edge RST_HOLD_CYCLES+SETTLE_CYCLES−1.
- ready rises on the edge after cfg_done is first sampled high in CONFIG; latency is 1 cycle.
- A failed attempt drops both chip resets and raises cfg_rst on the edge after the failure is detected.
- Both chip resets always move together.
- attempt never exceeds MAX_RETRY.

## Test plan

Parameters for all scenarios: RST_HOLD_CYCLES=4, SETTLE_CYCLES=3, TIMEOUT_CYCLES=10, MAX_RETRY=2, CNT_W=4.

1. **Normal bring-up.** Release rst_n; raise cfg_done 5 cycles after cfg_rst falls.
   - Chip resets rise after edge 3.
   - cfg_rst falls after edge 6.
   - ready=1 one cycle after cfg_done; attempt=0; fail stays 0.
2. **Retry on error.** Pulse cfg_error in CONFIG on attempts 0 and 1; give cfg_done on attempt 2.
   - Chip resets go low for exactly 4 cycles on each retry.
   - attempt steps 0→1→2.
   - ready=1, fail=0.
3. **Timeout exhaustion.** Never assert cfg_done or cfg_error.
   - Each CONFIG lasts exactly 10 cycles.
   - After 3 attempts: state=FAIL, fail=1, cfg_rst=1, chip resets high, attempt=2.
4. **Simultaneous done and error.** Raise cfg_done and cfg_error in the same CONFIG cycle.
   - Treated as error: attempt increments, state returns to HOLD, ready stays 0.
5. **Restart from DONE and FAIL, and mid-HOLD.** Pulse restart in each case.
   - Next edge: state=HOLD, attempt=0, ready=0, fail=0, chip resets low.
   - The full 4-cycle hold restarts.
6. **Reset mid-operation.** Assert rst_n=0 during CONFIG while also pulsing restart.
   - Reset values take effect on that edge.
   - cfg_done arriving during reset is ignored.
